// File: rtl/fpu_pkg.sv
// Shared widths and the unpacked-operand record for the FPU operand front end.
package fpu_pkg;

    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int SGL_EXP_W  = 8;
    localparam int SGL_FRAC_W = 23;
    localparam int SIG_W      = 53;
    localparam int LZ_W       = 6;

    typedef struct packed {
        logic                  s;
        logic [DBL_EXP_W-1:0]  e;
        logic                  e_z;
        logic                  e_inf;
        logic [SIG_W-1:0]      f;
        logic                  fz;
        logic [DBL_FRAC_W-1:0] h;
        logic [LZ_W-1:0]       lz;
    } unp_t;

endpackage

// File: rtl/lzc53.sv
// 53-bit leading-zero counter: log-depth halving search, returns 0 for an all-zero input.
module lzc53
    import fpu_pkg::*;
(
    input  logic [SIG_W-1:0] a,
    output logic [LZ_W-1:0]  cnt
);

    logic [63:0]     v0, v1, v2, v3, v4, v5;
    logic [LZ_W-1:0] c;

    // Padding the low end with ones caps the count at 52 for any non-zero input.
    always_comb begin
        v0   = {a, 11'h7FF};
        c[5] = (v0[63:32] == 32'h0);
        v1   = c[5] ? {v0[31:0], 32'h0} : v0;
        c[4] = (v1[63:48] == 16'h0);
        v2   = c[4] ? {v1[47:0], 16'h0} : v1;
        c[3] = (v2[63:56] == 8'h0);
        v3   = c[3] ? {v2[55:0], 8'h0} : v2;
        c[2] = (v3[63:60] == 4'h0);
        v4   = c[2] ? {v3[59:0], 4'h0} : v3;
        c[1] = (v4[63:62] == 2'h0);
        v5   = c[1] ? {v4[61:0], 2'h0} : v4;
        c[0] = ~v5[63];
        cnt  = (a == '0) ? '0 : c;
    end

endmodule

// File: rtl/fp_unpacker.sv
// Splits a double or single operand into sign, double-bias exponent, significand and class flags.
// Build option UNPACKER_FTZ_EN flushes denormal operands to zero (sign and emin exponent kept).
module fp_unpacker
    import fpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           fp,
    input  logic                  db,
    input  logic                  normal,
    output logic                  s,
    output logic [DBL_EXP_W-1:0]  e,
    output logic                  e_z,
    output logic                  e_inf,
    output logic [SIG_W-1:0]      f,
    output logic                  fz,
    output logic [DBL_FRAC_W-1:0] h,
    output logic [LZ_W-1:0]       lz
);

    logic                  ez, ei;
    logic [DBL_FRAC_W-1:0] fr;
    logic [DBL_EXP_W-1:0]  ex;
    logic [SGL_EXP_W-1:0]  x8;
    logic [SIG_W-1:0]      m;
    logic [LZ_W-1:0]       lz_c;
    unp_t                  nxt, q;
    logic                  unused_lo;

    assign unused_lo = ^fp[31:0];

    always_comb begin
        x8 = '0;
        if (db) begin
            ez = (fp[62:52] == '0);
            ei = &fp[62:52];
            fr = fp[51:0];
            ex = ez ? 11'd1 : fp[62:52];
        end else begin
            ez = (fp[62:55] == '0);
            ei = &fp[62:55];
            fr = {fp[54:32], 29'b0};
            x8 = ez ? 8'd1 : fp[62:55];
            // Bit-level rebias 127 -> 1023 (adds 896 for every code 1..255).
            ex = {x8[7], {3{~x8[7]}}, x8[6:0]};
        end
`ifdef UNPACKER_FTZ_EN
        if (ez) fr = '0;
`endif
        m = {~ez, fr};
    end

    lzc53 u_lzc (
        .a   (m),
        .cnt (lz_c)
    );

    always_comb begin
        nxt.s     = fp[63];
        nxt.e     = ex;
        nxt.e_z   = ez;
        nxt.e_inf = ei;
        nxt.f     = normal ? (m << lz_c) : m;
        nxt.fz    = (fr == '0);
        nxt.h     = fr;
        nxt.lz    = lz_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= nxt;
    end

    assign s     = q.s;
    assign e     = q.e;
    assign e_z   = q.e_z;
    assign e_inf = q.e_inf;
    assign f     = q.f;
    assign fz    = q.fz;
    assign h     = q.h;
    assign lz    = q.lz;

endmodule

// File: tb/tb_fp_unpacker.sv
// Self-checking bench for fp_unpacker: directed IEEE cases plus random vectors against a reference model.
module tb_fp_unpacker;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] fp;
    logic        db, normal;
    logic        s, e_z, e_inf, fz;
    logic [10:0] e;
    logic [52:0] f;
    logic [51:0] h;
    logic [5:0]  lz;

    int checks = 0;
    int errors = 0;

    fp_unpacker dut (
        .clk(clk), .rst_n(rst_n), .fp(fp), .db(db), .normal(normal),
        .s(s), .e(e), .e_z(e_z), .e_inf(e_inf), .f(f), .fz(fz), .h(h), .lz(lz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic rebias, bit-scan normalisation.
    function automatic unp_t model(input logic [63:0] x, input logic d, input logic n);
        unp_t r;
        int   exf, bits, msb;
        logic [51:0] fr;
        logic [52:0] m;
        bits = d ? 11 : 8;
        exf  = d ? int'(x[62:52]) : int'(x[62:55]);
        fr   = d ? x[51:0] : {x[54:32], 29'b0};
        r.s     = x[63];
        r.e_z   = (exf == 0);
        r.e_inf = (exf == (1 << bits) - 1);
`ifdef UNPACKER_FTZ_EN
        if (r.e_z) fr = '0;
`endif
        if (exf == 0) exf = 1;
        r.e  = d ? 11'(exf) : 11'(exf - 127 + 1023);
        m    = {~r.e_z, fr};
        msb  = -1;
        for (int i = 0; i < 53; i++) if (m[i]) msb = i;
        r.lz = (msb < 0) ? 6'd0 : 6'(52 - msb);
        r.f  = n ? (m << r.lz) : m;
        r.fz = (fr == '0);
        r.h  = fr;
        return r;
    endfunction

    task automatic check_out(input string tag, input unp_t x);
        chk({tag, ".s"},     64'(s),     64'(x.s));
        chk({tag, ".e"},     64'(e),     64'(x.e));
        chk({tag, ".e_z"},   64'(e_z),   64'(x.e_z));
        chk({tag, ".e_inf"}, 64'(e_inf), 64'(x.e_inf));
        chk({tag, ".f"},     64'(f),     64'(x.f));
        chk({tag, ".fz"},    64'(fz),    64'(x.fz));
        chk({tag, ".h"},     64'(h),     64'(x.h));
        chk({tag, ".lz"},    64'(lz),    64'(x.lz));
    endtask

    task automatic apply(input string tag, input logic [63:0] x, input logic d, input logic n);
        @(negedge clk);
        fp = x; db = d; normal = n;
        @(posedge clk);
        #1;
        check_out(tag, model(x, d, n));
    endtask

    initial begin
        logic [63:0] x;
        logic        d, n;
        int          cls;
        unp_t        zero_r;
        zero_r = '0;
        rst_n = 1'b0; fp = '0; db = 1'b0; normal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", zero_r);
        @(negedge clk);
        rst_n = 1'b1;

        apply("dbl_one", 64'h3FF0000000000000, 1'b1, 1'b1);
        chk("dbl_one_e", 64'(e), 64'h3FF);
        chk("dbl_one_f", 64'(f), 64'h10000000000000);
        chk("dbl_one_fz", 64'(fz), 64'd1);
        apply("dbl_min_dn", 64'h0000000000000001, 1'b1, 1'b1);
        chk("dbl_min_dn_e", 64'(e), 64'd1);
`ifndef UNPACKER_FTZ_EN
        chk("dbl_min_dn_lz", 64'(lz), 64'd52);
        chk("dbl_min_dn_f", 64'(f), 64'h10000000000000);
`else
        chk("dbl_min_dn_ftz_f", 64'(f), 64'd0);
        chk("dbl_min_dn_ftz_fz", 64'(fz), 64'd1);
`endif
        apply("dbl_min_dn_raw", 64'h0000000000000001, 1'b1, 1'b0);
        apply("dbl_ninf", 64'hFFF0000000000000, 1'b1, 1'b1);
        chk("dbl_ninf_inf", 64'(e_inf), 64'd1);
        apply("dbl_qnan", 64'h7FF8000000000000, 1'b1, 1'b1);
        chk("dbl_qnan_q", 64'(h[51]), 64'd1);
        apply("dbl_nzero", 64'h8000000000000000, 1'b1, 1'b1);
        chk("dbl_nzero_lz", 64'(lz), 64'd0);
        apply("sgl_one", 64'h3F80000000000000, 1'b0, 1'b1);
        chk("sgl_one_e", 64'(e), 64'h3FF);
        apply("sgl_one_lo", 64'h3F800000FFFFFFFF, 1'b0, 1'b1);
        chk("sgl_one_lo_f", 64'(f), 64'h10000000000000);
        apply("sgl_min_dn", 64'h0000000100000000, 1'b0, 1'b1);
        chk("sgl_min_dn_e", 64'(e), 64'h381);
        apply("sgl_inf", 64'h7F80000000000000, 1'b0, 1'b0);
        chk("sgl_inf_e", 64'(e), 64'h47F);
        apply("dbl_max", 64'h7FEFFFFFFFFFFFFF, 1'b1, 1'b1);
        chk("dbl_max_f", 64'(f), 64'h1FFFFFFFFFFFFF);

        for (int i = 0; i < 1000; i++) begin
            x   = {$urandom, $urandom};
            d   = 1'($urandom);
            n   = 1'($urandom);
            cls = int'($urandom_range(0, 4));
            if (cls == 1) begin
                if (d) x[62:52] = '0; else x[62:55] = '0;
            end else if (cls == 2) begin
                if (d) x[62:52] = '1; else x[62:55] = '1;
            end else if (cls == 3) begin
                if (d) x[62:52] = '0; else x[62:55] = '0;
                x[51:0] = 52'(x[51:0] >> $urandom_range(0, 51));
                x[54:32] = 23'(x[54:32] >> $urandom_range(0, 22));
            end
            apply("rand", x, d, n);
            if (i == 500) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_out("mid_reset", zero_r);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
